// File: rtl/ec551_lab2_pkg.sv
// Shared definitions for the lab 2 ASCII front end: character codes, line geometry and
// the line-buffer state type.
package ec551_lab2_pkg;

  localparam int LINE_CHARS = 14;
  localparam int CHAR_W     = 8;

  localparam logic [7:0] ASCII_BS       = 8'h08;
  localparam logic [7:0] ASCII_CR       = 8'h0D;
  localparam logic [7:0] ASCII_SP       = 8'h20;
  localparam logic [7:0] ASCII_DEL      = 8'h7F;
  localparam logic [7:0] ASCII_UC_A     = 8'h41;
  localparam logic [7:0] ASCII_UC_Z     = 8'h5A;
  localparam logic [7:0] ASCII_CASE_OFS = 8'h20;

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } line_state_t;

  function automatic logic is_upper(input logic [7:0] c);
    return (c >= ASCII_UC_A) && (c <= ASCII_UC_Z);
  endfunction

endpackage

// File: rtl/ascii_line_buffer_char_class.sv
// Combinational classifier for one ASCII code: printable / backspace / enter flags and the
// character to store. Define LOWERCASE_FOLD_EN to store 'A'..'Z' as 'a'..'z'.
module ascii_char_class
  import ec551_lab2_pkg::*;
(
  input  logic [7:0] char_in,
  output logic       is_printable,
  output logic       is_bs,
  output logic       is_cr,
  output logic [7:0] char_out
);

  always_comb begin
    is_printable = (char_in >= ASCII_SP) && (char_in < ASCII_DEL);
    is_bs        = (char_in == ASCII_BS);
    is_cr        = (char_in == ASCII_CR);
`ifdef LOWERCASE_FOLD_EN
    // Folding lets the downstream converter decode hex digits in either case.
    char_out     = is_upper(char_in) ? (char_in + ASCII_CASE_OFS) : char_in;
`else
    char_out     = char_in;
`endif
  end

endmodule

// File: rtl/ascii_line_buffer.sv
// Collects ASCII characters into a fixed-length line (backspace, commit on Enter) and hands
// it off with valid/ready. Optional LOWERCASE_FOLD_EN folds upper-case letters on entry.
module ascii_line_buffer #(
  parameter int NUM_CHARS = ec551_lab2_pkg::LINE_CHARS,
  parameter int CHAR_W    = ec551_lab2_pkg::CHAR_W,
  localparam int CNT_W    = $clog2(NUM_CHARS + 1)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [7:0]                  char_in,
  input  logic                        char_valid,
  output logic                        char_ready,
  output logic [NUM_CHARS*CHAR_W-1:0] line_out,
  output logic                        line_valid,
  input  logic                        line_ready,
  output logic [CNT_W-1:0]            char_count,
  output logic                        overflow
);

  import ec551_lab2_pkg::*;

  line_state_t state, next_state;

  logic [NUM_CHARS-1:0][CHAR_W-1:0] line_buf;
  logic [CNT_W-1:0]                 count;
  logic                             overflow_q;

  logic       is_printable, is_bs, is_cr;
  logic [7:0] char_folded;
  logic       accept, handoff, full, empty;

  ascii_char_class u_class (
    .char_in      (char_in),
    .is_printable (is_printable),
    .is_bs        (is_bs),
    .is_cr        (is_cr),
    .char_out     (char_folded)
  );

  // Handshakes decoded from the state register directly to keep the FSM free of comb loops.
  assign accept  = char_valid && (state == COLLECT);
  assign handoff = line_ready && (state == HOLD);
  assign full    = (count == CNT_W'(NUM_CHARS));
  assign empty   = (count == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= COLLECT;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    char_ready = 1'b0;
    line_valid = 1'b0;
    case (state)
      COLLECT: begin
        char_ready = 1'b1;
        if (accept && is_cr && !empty) begin
          next_state = HOLD;
        end
      end
      HOLD: begin
        line_valid = 1'b1;
        if (handoff) begin
          next_state = COLLECT;
        end
      end
      default: next_state = COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_buf   <= '0;
      count      <= '0;
      overflow_q <= 1'b0;
    end else if (handoff) begin
      line_buf   <= '0;
      count      <= '0;
      overflow_q <= 1'b0;
    end else if (accept) begin
      if (is_printable) begin
        if (!full) begin
          line_buf[count] <= CHAR_W'(char_folded);
          count           <= count + 1'b1;
        end else begin
          overflow_q <= 1'b1;
        end
      end else if (is_bs && !empty) begin
        line_buf[count - 1'b1] <= '0;
        count                  <= count - 1'b1;
      end
    end
  end

  assign line_out   = line_buf;
  assign char_count = count;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_ascii_line_buffer.sv
// Directed self-checking bench for ascii_line_buffer: typing, backspace, Enter, overflow,
// hold/handoff, reset mid-line and the optional LOWERCASE_FOLD_EN case folding.
module tb_ascii_line_buffer;

  logic         clk;
  logic         rst_n;
  logic [7:0]   char_in;
  logic         char_valid;
  logic         char_ready;
  logic [111:0] line_out;
  logic         line_valid;
  logic         line_ready;
  logic [3:0]   char_count;
  logic         overflow;

  int assertCount = 0;
  int failCount   = 0;

  ascii_line_buffer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .char_in    (char_in),
    .char_valid (char_valid),
    .char_ready (char_ready),
    .line_out   (line_out),
    .line_valid (line_valid),
    .line_ready (line_ready),
    .char_count (char_count),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [111:0] actual,
                             input logic [111:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Presents one character for a single clock; returns on the following falling edge.
  task automatic applyStimulus(input logic [7:0] c);
    char_in    = c;
    char_valid = 1'b1;
    @(negedge clk);
    char_valid = 1'b0;
  endtask

  task automatic typeString(input string s);
    for (int i = 0; i < s.len(); i++) begin
      applyStimulus(s[i]);
    end
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    logic [111:0] expLine;
    string        longStr;

    rst_n      = 1'b0;
    char_in    = 8'h00;
    char_valid = 1'b0;
    line_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    checkOutput("reset_char_ready", 112'(char_ready), 112'd1);
    checkOutput("reset_line_valid", 112'(line_valid), 112'd0);
    checkOutput("reset_count",      112'(char_count), 112'd0);
    checkOutput("reset_line",       line_out,         112'd0);
    checkOutput("reset_overflow",   112'(overflow),   112'd0);

    // "12a"
    typeString("12a");
    checkOutput("12a_line",  line_out,         {88'd0, 24'h613231});
    checkOutput("12a_count", 112'(char_count), 112'd3);
    checkOutput("12a_valid", 112'(line_valid), 112'd0);

    // "123", BS, "4", CR
    doReset();
    typeString("123");
    applyStimulus(8'h08);
    checkOutput("bs_count", 112'(char_count), 112'd2);
    checkOutput("bs_line",  line_out,         {96'd0, 16'h3231});
    applyStimulus("4");
    applyStimulus(8'h0D);
    checkOutput("cr_valid", 112'(line_valid), 112'd1);
    checkOutput("cr_ready", 112'(char_ready), 112'd0);
    checkOutput("cr_line",  line_out,         {88'd0, 24'h343231});
    checkOutput("cr_count", 112'(char_count), 112'd3);
    line_ready = 1'b1;
    @(negedge clk);
    line_ready = 1'b0;
    checkOutput("handoff_valid", 112'(line_valid), 112'd0);
    checkOutput("handoff_ready", 112'(char_ready), 112'd1);
    checkOutput("handoff_count", 112'(char_count), 112'd0);
    checkOutput("handoff_line",  line_out,         112'd0);

    // 16 printable characters: only the first 14 are kept
    longStr = "0123456789abcdef";
    expLine = '0;
    for (int i = 0; i < 14; i++) begin
      expLine[8*i +: 8] = longStr[i];
    end
    typeString(longStr.substr(0, 13));
    checkOutput("full_count",    112'(char_count), 112'd14);
    checkOutput("full_overflow", 112'(overflow),   112'd0);
    typeString(longStr.substr(14, 15));
    checkOutput("ovf_count",    112'(char_count), 112'd14);
    checkOutput("ovf_overflow", 112'(overflow),   112'd1);
    checkOutput("ovf_line",     line_out,         expLine);
    applyStimulus(8'h0D);
    checkOutput("ovf_cr_valid", 112'(line_valid), 112'd1);
    line_ready = 1'b1;
    @(negedge clk);
    line_ready = 1'b0;
    checkOutput("ovf_clear_overflow", 112'(overflow),   112'd0);
    checkOutput("ovf_clear_count",    112'(char_count), 112'd0);

    // CR, BS and non-printable codes on an empty line are ignored
    applyStimulus(8'h0D);
    applyStimulus(8'h08);
    applyStimulus(8'h7F);
    applyStimulus(8'h01);
    checkOutput("empty_valid", 112'(line_valid), 112'd0);
    checkOutput("empty_ready", 112'(char_ready), 112'd1);
    checkOutput("empty_count", 112'(char_count), 112'd0);
    checkOutput("empty_line",  line_out,         112'd0);

    // HOLD ignores characters until the consumer takes the line
    typeString("9");
    applyStimulus(8'h0D);
    char_in    = "x";
    char_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("hold_ready", 112'(char_ready), 112'd0);
      checkOutput("hold_line",  line_out,         {104'd0, 8'h39});
      checkOutput("hold_count", 112'(char_count), 112'd1);
    end
    line_ready = 1'b1;
    @(negedge clk);
    char_valid = 1'b0;
    line_ready = 1'b0;
    checkOutput("hold_rel_ready", 112'(char_ready), 112'd1);
    checkOutput("hold_rel_count", 112'(char_count), 112'd0);
    checkOutput("hold_rel_line",  line_out,         112'd0);

    // line_ready held high: HOLD lasts exactly one cycle
    line_ready = 1'b1;
    typeString("7");
    applyStimulus(8'h0D);
    checkOutput("fast_valid", 112'(line_valid), 112'd1);
    checkOutput("fast_line",  line_out,         {104'd0, 8'h37});
    @(negedge clk);
    checkOutput("fast_valid_drop", 112'(line_valid), 112'd0);
    checkOutput("fast_count",      112'(char_count), 112'd0);
    line_ready = 1'b0;

    // Case folding, then asynchronous reset mid-line
    typeString("AF");
`ifdef LOWERCASE_FOLD_EN
    checkOutput("fold_line", line_out, {96'd0, 16'h6661});
`else
    checkOutput("fold_line", line_out, {96'd0, 16'h4641});
`endif
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_rst_line",  line_out,         112'd0);
    checkOutput("async_rst_count", 112'(char_count), 112'd0);
    checkOutput("async_rst_ready", 112'(char_ready), 112'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("post_rst_valid", 112'(line_valid), 112'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
